// File: rtl/isqrt_seq_if.sv
// Handshake and result bundle for the sequential integer square-root unit.
// The master side issues jobs; the slave side is the root engine.
interface isqrt_seq_if #(
    parameter int WIDTH = 16
);
    logic               start_i;
    logic               round_i;
    logic [WIDTH-1:0]   a_i;
    logic               busy_o;
    logic               done_o;
    logic [WIDTH/2:0]   y_bo;
    logic [WIDTH/2:0]   rem_bo;

    modport master (
        output start_i, round_i, a_i,
        input  busy_o, done_o, y_bo, rem_bo
    );

    modport slave (
        input  start_i, round_i, a_i,
        output busy_o, done_o, y_bo, rem_bo
    );
endinterface

// File: rtl/isqrt_seq.sv
// Multi-cycle integer square root: one root bit per clock (restoring digit recurrence),
// floor remainder, and optional round-to-nearest of the root.
module isqrt_seq #(
    parameter int WIDTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    isqrt_seq_if.slave  bus
);
    localparam int H  = WIDTH / 2;
    localparam int PW = H + 2;
    localparam int KW = $clog2(H + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    generate
        if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("isqrt_seq: WIDTH must be even and >= 4");
        end
    endgenerate

    logic [1:0]       state;
    logic [WIDTH-1:0] x;
    logic             mode;
    logic [H-1:0]     r;
    logic [PW-1:0]    p;
    logic [KW-1:0]    k;

    logic [PW-1:0]    p_sh;
    logic [PW-1:0]    t;
    logic [PW-1:0]    p_sub;
    logic             ge;
    logic             round_up;
    logic [H:0]       y_fin;

    // The top two bits of p are always zero before the shift, so dropping them is lossless.
    always_comb begin
        p_sh     = {p[PW-3:0], x[WIDTH-1 -: 2]};
        t        = {r, 2'b01};
        ge       = (p_sh >= t);
        p_sub    = p_sh - t;
        // Remainder above the floor root means sqrt(a) lies at or past r + 0.5.
        round_up = mode && (p > {2'b00, r});
        y_fin    = {1'b0, r} + {{H{1'b0}}, round_up};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            x          <= '0;
            mode       <= 1'b0;
            r          <= '0;
            p          <= '0;
            k          <= '0;
            bus.busy_o <= 1'b0;
            bus.done_o <= 1'b0;
            bus.y_bo   <= '0;
            bus.rem_bo <= '0;
        end else begin
            bus.done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        x          <= bus.a_i;
                        mode       <= bus.round_i;
                        r          <= '0;
                        p          <= '0;
                        k          <= KW'(H);
                        bus.busy_o <= 1'b1;
                        state      <= S_CALC;
                    end
                end
                S_CALC: begin
                    x <= x << 2;
                    if (ge) begin
                        p <= p_sub;
                        r <= {r[H-2:0], 1'b1};
                    end else begin
                        p <= p_sh;
                        r <= {r[H-2:0], 1'b0};
                    end
                    k <= k - 1'b1;
                    if (k == KW'(1))
                        state <= S_FINISH;
                end
                S_FINISH: begin
                    bus.rem_bo <= p[H:0];
                    bus.y_bo   <= y_fin;
                    bus.done_o <= 1'b1;
                    bus.busy_o <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
